// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM/WB register info in,
// stall/flush/forward controls, ecall handshake and perf counters out.
interface hazard_ctrl_if #(
    parameter int unsigned RegAddrBits = 5,
    parameter int unsigned RsltSrcBits = 2,
    parameter int unsigned CNT_WIDTH   = 32
);
    logic [RegAddrBits-1:0] rs1_D, rs2_D;
    logic [RegAddrBits-1:0] rs1_E, rs2_E, rd_E;
    logic [RegAddrBits-1:0] rd_M, rd_W;
    logic                   regWrite_E, regWrite_M, regWrite_W;
    logic [RsltSrcBits-1:0] resultSrc_E;
    logic                   pcSrc_E;
    logic                   ecall_E;
    logic                   ecall_ack;

    logic                   stall_F, stall_D;
    logic                   flush_D, flush_E;
    logic [1:0]             forwardA_E, forwardB_E;
    logic                   ecall_req;
    logic [CNT_WIDTH-1:0]   stall_cycles, redirect_count;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output regWrite_E, regWrite_M, regWrite_W, resultSrc_E,
        output pcSrc_E, ecall_E, ecall_ack,
        input  stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
        input  ecall_req, stall_cycles, redirect_count
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  regWrite_E, regWrite_M, regWrite_W, resultSrc_E,
        input  pcSrc_E, ecall_E, ecall_ack,
        output stall_F, stall_D, flush_D, flush_E, forwardA_E, forwardB_E,
        output ecall_req, stall_cycles, redirect_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: load-use stall, branch flush,
// EX operand forwarding, ecall drain/handshake FSM and saturating hazard counters.
module hazard_ctrl #(
    parameter int unsigned            RegAddrBits  = 5,
    parameter int unsigned            RsltSrcBits  = 2,
    parameter logic [RsltSrcBits-1:0] LOAD_SRC     = 2'b01,
    parameter int unsigned            DRAIN_CYCLES = 2,
    parameter int unsigned            CNT_WIDTH    = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz_io
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDrain   = 2'd1;
    localparam logic [1:0] StWaitAck = 2'd2;

    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

    logic lw, ecall_busy, stall;

    // MEM beats WB; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [RegAddrBits-1:0] src,
                                           input logic [RegAddrBits-1:0] rd_m,
                                           input logic [RegAddrBits-1:0] rd_w,
                                           input logic                   we_m,
                                           input logic                   we_w);
        if (we_m && (rd_m != '0) && (rd_m == src)) return 2'b10;
        if (we_w && (rd_w != '0) && (rd_w == src)) return 2'b01;
        return 2'b00;
    endfunction

    assign lw = hz_io.regWrite_E && (hz_io.resultSrc_E == LOAD_SRC) && (hz_io.rd_E != '0) &&
                ((hz_io.rd_E == hz_io.rs1_D) || (hz_io.rd_E == hz_io.rs2_D));

    assign ecall_busy = (state_q != StIdle) || hz_io.ecall_E;
    assign stall      = lw || ecall_busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            StIdle: begin
                if (hz_io.ecall_E) begin
                    if (DRAIN_CYCLES == 1) begin
                        state_d = StWaitAck;
                        req_d   = 1'b1;
                    end else begin
                        state_d = StDrain;
                        cnt_d   = DrainInit;
                    end
                end
            end
            StDrain: begin
                // Leaving when the count would hit zero puts req exactly
                // DRAIN_CYCLES edges after the ecall was accepted.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StWaitAck;
                    req_d   = 1'b1;
                end
            end
            StWaitAck: begin
                if (hz_io.ecall_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (hz_io.pcSrc_E && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    // Every output is held low while reset is asserted, including this cycle.
    always_comb begin
        hz_io.stall_F        = 1'b0;
        hz_io.stall_D        = 1'b0;
        hz_io.flush_D        = 1'b0;
        hz_io.flush_E        = 1'b0;
        hz_io.forwardA_E     = 2'b00;
        hz_io.forwardB_E     = 2'b00;
        hz_io.ecall_req      = 1'b0;
        hz_io.stall_cycles   = '0;
        hz_io.redirect_count = '0;
        if (!reset) begin
            hz_io.stall_F        = stall;
            hz_io.stall_D        = stall;
            hz_io.flush_D        = hz_io.pcSrc_E;
            hz_io.flush_E        = stall || hz_io.pcSrc_E;
            hz_io.forwardA_E     = fwd_sel(hz_io.rs1_E, hz_io.rd_M, hz_io.rd_W,
                                           hz_io.regWrite_M, hz_io.regWrite_W);
            hz_io.forwardB_E     = fwd_sel(hz_io.rs2_E, hz_io.rd_M, hz_io.rd_W,
                                           hz_io.regWrite_M, hz_io.regWrite_W);
            hz_io.ecall_req      = req_q;
            hz_io.stall_cycles   = stall_cnt_q;
            hz_io.redirect_count = redir_cnt_q;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand sequences for ecall,
// saturation and reset, then random traffic against a timestamp-based model.
module tb_hazard_ctrl;

    localparam int unsigned DRAIN = 2;
    localparam int unsigned CW    = 4;
    localparam int unsigned CMAX  = 15;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic       regWrite_E, regWrite_M, regWrite_W;
        logic [1:0] resultSrc_E;
        logic       pcSrc_E, ecall_E, ecall_ack;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [1:0] fa, fb;
        logic       stall, fd, fe;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RegAddrBits(5), .RsltSrcBits(2), .CNT_WIDTH(CW)) hz ();

    hazard_ctrl #(
        .RegAddrBits (5),
        .RsltSrcBits (2),
        .LOAD_SRC    (2'b01),
        .DRAIN_CYCLES(DRAIN),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz_io(hz)
    );

    int  n_chk = 0;
    int  n_err = 0;
    in_t cur;

    // Model state: an accepted ecall and how many edges have passed since.
    bit  m_busy  = 1'b0;
    int  m_since = 0;
    int  m_stall = 0;
    int  m_redir = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t vin(input logic [4:0] rs1_d, input logic [4:0] rs2_d,
                                input logic [4:0] rs1_e, input logic [4:0] rs2_e,
                                input logic [4:0] rd_e, input logic [4:0] rd_m,
                                input logic [4:0] rd_w, input logic we_e, input logic we_m,
                                input logic we_w, input logic [1:0] src, input logic pc);
        in_t v = '0;
        v.rs1_D = rs1_d; v.rs2_D = rs2_d; v.rs1_E = rs1_e; v.rs2_E = rs2_e;
        v.rd_E = rd_e; v.rd_M = rd_m; v.rd_W = rd_w;
        v.regWrite_E = we_e; v.regWrite_M = we_m; v.regWrite_W = we_w;
        v.resultSrc_E = src; v.pcSrc_E = pc;
        return v;
    endfunction

    task automatic apply(input in_t v);
        cur             = v;
        reset           = v.reset;
        hz.rs1_D        = v.rs1_D;       hz.rs2_D      = v.rs2_D;
        hz.rs1_E        = v.rs1_E;       hz.rs2_E      = v.rs2_E;
        hz.rd_E         = v.rd_E;        hz.rd_M       = v.rd_M;
        hz.rd_W         = v.rd_W;        hz.regWrite_E = v.regWrite_E;
        hz.regWrite_M   = v.regWrite_M;  hz.regWrite_W = v.regWrite_W;
        hz.resultSrc_E  = v.resultSrc_E; hz.pcSrc_E    = v.pcSrc_E;
        hz.ecall_E      = v.ecall_E;     hz.ecall_ack  = v.ecall_ack;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] x);
        if (cur.regWrite_M && cur.rd_M != 0 && cur.rd_M == x) return 2'b10;
        if (cur.regWrite_W && cur.rd_W != 0 && cur.rd_W == x) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lw();
        return cur.regWrite_E && cur.resultSrc_E == 2'b01 && cur.rd_E != 0 &&
               (cur.rd_E == cur.rs1_D || cur.rd_E == cur.rs2_D);
    endfunction

    function automatic bit m_stall_now();
        return m_lw() || m_busy || cur.ecall_E;
    endfunction

    task automatic check_model();
        bit r = cur.reset;
        chk("stall_F", hz.stall_F, !r && m_stall_now());
        chk("stall_D", hz.stall_D, !r && m_stall_now());
        chk("flush_D", hz.flush_D, !r && cur.pcSrc_E);
        chk("flush_E", hz.flush_E, !r && (m_stall_now() || cur.pcSrc_E));
        chk("forwardA", hz.forwardA_E, r ? 2'b00 : m_fwd(cur.rs1_E));
        chk("forwardB", hz.forwardB_E, r ? 2'b00 : m_fwd(cur.rs2_E));
        chk("ecall_req", hz.ecall_req, !r && m_busy && m_since >= DRAIN);
        chk("stall_cycles", hz.stall_cycles, r ? 0 : m_stall);
        chk("redirect_count", hz.redirect_count, r ? 0 : m_redir);
    endtask

    task automatic tick();
        if (cur.reset) begin
            m_busy = 1'b0; m_since = 0; m_stall = 0; m_redir = 0;
        end else begin
            if (m_stall_now() && m_stall < CMAX) m_stall++;
            if (cur.pcSrc_E && m_redir < CMAX) m_redir++;
            if (m_busy) begin
                if (m_since >= DRAIN && cur.ecall_ack) m_busy = 1'b0;
                else m_since++;
            end else if (cur.ecall_E) begin
                m_busy  = 1'b1;
                m_since = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t v = '0;
        v.reset = 1'b1;
        apply(v);
        #4;
        check_model();
        tick();
    endtask

    vec_t tbl[10];

    initial begin
        in_t v;
        tbl[0] = '{vin(0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0), 2'b10, 2'b00, 0, 0, 0};
        tbl[1] = '{vin(0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 0, 0), 2'b01, 2'b00, 0, 0, 0};
        tbl[2] = '{vin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 2'b00, 2'b00, 0, 0, 0};
        tbl[3] = '{vin(0, 0, 3, 6, 0, 3, 6, 0, 1, 1, 0, 0), 2'b10, 2'b01, 0, 0, 0};
        tbl[4] = '{vin(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0), 2'b00, 2'b00, 1, 0, 1};
        tbl[5] = '{vin(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0), 2'b00, 2'b00, 0, 0, 0};
        tbl[6] = '{vin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 2'b00, 2'b00, 0, 0, 0};
        tbl[7] = '{vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 2'b00, 2'b00, 0, 1, 1};
        tbl[8] = '{vin(7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1), 2'b00, 2'b00, 1, 1, 1};
        tbl[9] = '{vin(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0), 2'b00, 2'b00, 0, 0, 0};

        do_reset();
        chk("reset_stall_cycles", hz.stall_cycles, 0);
        chk("reset_ecall_req", hz.ecall_req, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            #4;
            chk($sformatf("vec%0d_fwdA", i), hz.forwardA_E, tbl[i].fa);
            chk($sformatf("vec%0d_fwdB", i), hz.forwardB_E, tbl[i].fb);
            chk($sformatf("vec%0d_stall", i), hz.stall_F, tbl[i].stall);
            chk($sformatf("vec%0d_flushD", i), hz.flush_D, tbl[i].fd);
            chk($sformatf("vec%0d_flushE", i), hz.flush_E, tbl[i].fe);
            check_model();
            tick();
            if (i == 7) chk("redirect_after_branch", hz.redirect_count, 1);
        end

        // Ecall: accepted at k=0, req from k=2, ack at k=5, released at k=6.
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            v = '0;
            v.ecall_E   = (k == 0);
            v.ecall_ack = (k == 5);
            apply(v);
            #4;
            chk($sformatf("ecall_k%0d_req", k), hz.ecall_req, (k >= 2 && k <= 5));
            chk($sformatf("ecall_k%0d_stall", k), hz.stall_D, (k <= 5));
            chk($sformatf("ecall_k%0d_flushE", k), hz.flush_E, (k <= 5));
            if (k == 6) chk("ecall_stall_cycles", hz.stall_cycles, 6);
            check_model();
            tick();
        end

        // Saturation: 20 stalled edges into a 4-bit counter.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            apply(vin(0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0));
            #4;
            check_model();
            tick();
        end
        apply('0);
        #4;
        chk("saturated_stall_cycles", hz.stall_cycles, 4'hF);
        tick();

        // Reset while waiting for ack, then a stray ack.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            v = '0;
            v.ecall_E = (k == 0);
            apply(v);
            #4;
            check_model();
            tick();
        end
        v = vin(7, 3, 3, 3, 7, 3, 3, 1, 1, 1, 1, 1);
        v.reset = 1'b1; v.ecall_E = 1'b1; v.ecall_ack = 1'b1;
        apply(v);
        #4;
        chk("rst_stall_F", hz.stall_F, 0);
        chk("rst_flush_D", hz.flush_D, 0);
        chk("rst_flush_E", hz.flush_E, 0);
        chk("rst_fwdA", hz.forwardA_E, 0);
        chk("rst_ecall_req", hz.ecall_req, 0);
        chk("rst_stall_cycles", hz.stall_cycles, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            v = '0;
            v.ecall_ack = (k == 0);
            apply(v);
            #4;
            chk($sformatf("stray_ack_k%0d_req", k), hz.ecall_req, 0);
            chk($sformatf("stray_ack_k%0d_stall", k), hz.stall_F, 0);
            tick();
        end

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            v.reset       = ($urandom_range(0, 49) == 0);
            v.rs1_D       = 5'($urandom_range(0, 3));
            v.rs2_D       = 5'($urandom_range(0, 3));
            v.rs1_E       = 5'($urandom_range(0, 3));
            v.rs2_E       = 5'($urandom_range(0, 3));
            v.rd_E        = 5'($urandom_range(0, 3));
            v.rd_M        = 5'($urandom_range(0, 3));
            v.rd_W        = 5'($urandom_range(0, 3));
            v.regWrite_E  = 1'($urandom_range(0, 1));
            v.regWrite_M  = 1'($urandom_range(0, 1));
            v.regWrite_W  = 1'($urandom_range(0, 1));
            v.resultSrc_E = 2'($urandom_range(0, 3));
            v.pcSrc_E     = ($urandom_range(0, 5) == 0);
            v.ecall_E     = ($urandom_range(0, 7) == 0);
            v.ecall_ack   = ($urandom_range(0, 2) == 0);
            apply(v);
            #4;
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined core. It consumes the ID/EX register outputs and the EX/MEM and MEM/WB destination info.
- Drives back into the pipeline: stall for IF/ID, flush for IF/ID and ID/EX, and the EX operand forwarding selects.
- Contains an ecall drain/handshake FSM and saturating hazard performance counters.

Parameters:
RegAddrBits, 5, register address width
RsltSrcBits, 2, resultSrc width
LOAD_SRC, 2'b01, resultSrc encoding meaning "result from data memory"
DRAIN_CYCLES, 2, bubble cycles inserted after ecall enters EX before ecall_req (range 1..15)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rs1_D, rs2_D  in  RegAddrBits  source regs of instruction in ID
rs1_E, rs2_E  in  RegAddrBits  source regs in EX (ID/EX readRegister1/2)
rd_E  in  RegAddrBits  dest reg in EX
regWrite_E  in  1  EX writes register
resultSrc_E  in  RsltSrcBits  EX result source
pcSrc_E  in  1  taken branch/jal/jalr resolved in EX
ecall_E  in  1  ecall in EX
rd_M, rd_W  in  RegAddrBits  dest regs in MEM, WB
regWrite_M, regWrite_W  in  1  write enables in MEM, WB
ecall_ack  in  1  environment finished servicing ecall
stall_F, stall_D  out  1  hold PC / IF-ID register
flush_D, flush_E  out  1  bubble IF-ID / ID-EX register
forwardA_E, forwardB_E  out  2  00 regfile, 10 from MEM, 01 from WB
ecall_req  out  1  registered service request
stall_cycles  out  CNT_WIDTH  cycles with stall_D=1
redirect_count  out  CNT_WIDTH  cycles with pcSrc_E=1

Behaviour:
- Reset: while reset=1, all outputs are forced 0 combinationally in the same cycle. At the clock edge: state=IDLE, drain counter=0, ecall_req=0, both counters=0. Reset mid-ecall abandons the request; no ack is required afterwards.
- Forwarding (combinational, per operand X in {rs1_E, rs2_E}):
  - 10 if regWrite_M && rd_M!=0 && rd_M==X.
  - Else 01 if regWrite_W && rd_W!=0 && rd_W==X.
  - Else 00.
  - MEM has priority over WB. x0 never forwards.
- Load-use (combinational): lw = regWrite_E && resultSrc_E==LOAD_SRC && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
- Ecall FSM, states IDLE, DRAIN, WAIT_ACK:
  - IDLE: if ecall_E → DRAIN, cnt<=DRAIN_CYCLES-1; the entry cycle already stalls and flushes. If DRAIN_CYCLES==1 → WAIT_ACK directly, ecall_req<=1.
  - DRAIN: cnt decrements each cycle. When cnt==0 → WAIT_ACK, ecall_req<=1.
  - WAIT_ACK: ecall_req held at 1. On ecall_ack → IDLE, ecall_req<=0 at the same edge.
  - ecall_ack outside WAIT_ACK is ignored. ecall_E outside IDLE is ignored.
  - ecall_busy = (state!=IDLE) || (state==IDLE && ecall_E).
- Combined outputs:
  - stall_F = stall_D = lw | ecall_busy.
  - flush_D = pcSrc_E.
  - flush_E = lw | pcSrc_E | ecall_busy.
  - pcSrc_E and lw in the same cycle: both flushes=1 and stall=1. The redirect still wins because the PC mux loads the target when pcSrc_E=1 regardless of stall_F.
- Latency: forward, stall and flush are combinational, zero cycles. ecall_req rises exactly DRAIN_CYCLES clock edges after the first cycle ecall_E=1 in IDLE.
- Counters:
  - stall_cycles += 1 each clock edge where stall_D=1; redirect_count += 1 where pcSrc_E=1.
  - Both saturate at all-ones with no wrap, and do not count while reset=1.

Test Plan:
- Forwarding: rs1_E=5, rd_M=5/regWrite_M=1, rd_W=5/regWrite_W=1 → forwardA_E=10. Drop regWrite_M → 01. Set rs1_E=0, rd_M=0 → 00.
- Load-use: rd_E=7, resultSrc_E=01, regWrite_E=1, rs2_D=7 → stall_F=stall_D=flush_E=1, flush_D=0 for one cycle. With resultSrc_E=00 → all 0.
- Branch redirect: pcSrc_E=1 for one cycle → flush_D=flush_E=1, stall=0, redirect_count goes 0→1.
- Ecall, DRAIN_CYCLES=2:
  - ecall_E=1 at cycle t → stall/flush_E=1 from cycle t, ecall_req=1 from t+2.
  - ecall_ack at t+5 → ecall_req=0 and stall=0 at t+6.
  - stall_cycles=6 at t+6.
- Saturation, CNT_WIDTH=4: hold lw condition for 20 cycles → stall_cycles stays 4'hF and does not wrap.
- Reset in WAIT_ACK: reset=1 → all outputs 0 in the same cycle. After release, state is IDLE and a stray ecall_ack produces no ecall_req.
